// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl
//   Valid/ready front end and result collector for a 32-bit barrel shifter
//   that has a fixed one-cycle latency. The controller decodes each request
//   into the shifter's control inputs and tracks the op that is in flight.
//   Results are queued in a DEPTH-entry FIFO. Requests are accepted only when
//   the FIFO has room for every op that could still land in it, because the
//   shifter cannot be stalled.
//
// Ports
//   i_clk, i_rst_n        clock; asynchronous active-low reset
//   s_valid/s_ready       request handshake
//   s_op/s_amt/s_data     request: op (00 SLL, 01 SRL, 10 SRA, 11 reserved),
//                         shift amount, operand
//   s_tag                 opaque tag, returned with the result
//   o_sh_*                combinational control/data to the shifter
//   i_sh_result           shifter output, valid the cycle after issue
//   m_valid/m_ready       result handshake; m_data/m_tag are the FIFO head
//   o_err_illegal         sticky flag, set when a reserved op is accepted
module shift_issue_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:0]       s_op,
    input  logic [4:0]       s_amt,
    input  logic [31:0]      s_data,
    input  logic [TAG_W-1:0] s_tag,
    output logic [31:0]      o_sh_data,
    output logic [4:0]       o_sh_amt,
    output logic             o_sh_left,
    output logic             o_sh_signed,
    input  logic [31:0]      i_sh_result,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic [TAG_W-1:0] m_tag,
    output logic             o_err_illegal
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    op_e op;
    assign op = op_e'(s_op);

    logic [31:0]      data_q [DEPTH];
    logic [TAG_W-1:0] tagm_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             issued_q, issued_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;

    logic accept, push, pop;

    // Reserved op becomes a logical right shift by zero, so the operand
    // passes through unchanged.
    always_comb begin
        o_sh_data   = s_data;
        o_sh_amt    = s_amt;
        o_sh_left   = 1'b0;
        o_sh_signed = 1'b0;
        case (op)
            OP_SLL:  o_sh_left   = 1'b1;
            OP_SRL:  ;
            OP_SRA:  o_sh_signed = 1'b1;
            default: o_sh_amt    = '0;
        endcase
    end

    // Credit: the in-flight op already owns a FIFO slot, so it is counted
    // together with the queued results. m_ready deliberately plays no part.
    assign s_ready = i_rst_n & ((count_q + CNT_W'(issued_q)) < CNT_W'(DEPTH));
    assign accept  = s_valid & s_ready;
    assign push    = issued_q;
    assign m_valid = (count_q != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = data_q[rd_ptr_q];
    assign m_tag   = tagm_q[rd_ptr_q];
    assign o_err_illegal = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issued_d = accept;
        tag_d    = tag_q;
        err_d    = err_q;
        if (accept) begin
            tag_d = s_tag;
            if (op == OP_RSVD) err_d = 1'b1;
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= 1'b0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tagm_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            if (push) begin
                data_q[wr_ptr_q] <= i_sh_result;
                tagm_q[wr_ptr_q] <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_ctrl.sv
module tb_shift_issue_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [1:0]       s_op = '0;
    logic [4:0]       s_amt = '0;
    logic [31:0]      s_data = '0;
    logic [TAG_W-1:0] s_tag = '0;
    logic [31:0]      sh_data;
    logic [4:0]       sh_amt;
    logic             sh_left;
    logic             sh_signed;
    logic [31:0]      sh_result = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [31:0]      m_data;
    logic [TAG_W-1:0] m_tag;
    logic             err;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t exp_q[$];

    shift_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_amt(s_amt),
        .s_data(s_data), .s_tag(s_tag),
        .o_sh_data(sh_data), .o_sh_amt(sh_amt), .o_sh_left(sh_left),
        .o_sh_signed(sh_signed), .i_sh_result(sh_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
        .o_err_illegal(err)
    );

    always #5 clk = ~clk;

    // External shifter: registered, one-cycle latency, never reset.
    always @(posedge clk) begin
        if (sh_left)        sh_result <= sh_data << sh_amt;
        else if (sh_signed) sh_result <= $unsigned($signed(sh_data) >>> sh_amt);
        else                sh_result <= sh_data >> sh_amt;
    end

    function automatic logic [31:0] ref_shift(logic [1:0] op, logic [4:0] amt, logic [31:0] d);
        case (op)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            2'b10:   return $unsigned($signed(d) >>> amt);
            default: return d;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Accept side: inputs change just after posedge, so negedge values are
    // what the next posedge will see.
    always @(negedge clk) begin
        if (rst_n && s_valid && s_ready) begin
            chk("credit_room", 32'(exp_q.size() < DEPTH), 32'd1);
            exp_q.push_back('{data: ref_shift(s_op, s_amt, s_data), tag: s_tag});
            acc_cnt++;
        end
    end

    // Result side.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", m_data, e.data);
                chk("res_tag", 32'(m_tag), 32'(e.tag));
            end
            pop_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] amt,
                         input logic [31:0] d, input logic [TAG_W-1:0] tag);
        s_valid = 1'b1;
        s_op    = op;
        s_amt   = amt;
        s_data  = d;
        s_tag   = tag;
    endtask

    task automatic one_op(input logic [1:0] op, input logic [4:0] amt,
                          input logic [31:0] d, input logic [TAG_W-1:0] tag);
        drive(op, amt, d, tag);
        tick();
        s_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_tag", 32'(m_tag), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_s_ready", 32'(s_ready), 32'd1);

        // Combinational decode, independent of s_valid
        s_data = 32'hA5A5_0F0F;
        s_amt  = 5'd13;
        s_op = 2'b00; #1;
        chk("dec_sll", {sh_data[31:0]}, 32'hA5A5_0F0F);
        chk("dec_sll_ctl", {25'd0, sh_amt, sh_left, sh_signed}, {25'd0, 5'd13, 1'b1, 1'b0});
        s_op = 2'b01; #1;
        chk("dec_srl_ctl", {25'd0, sh_amt, sh_left, sh_signed}, {25'd0, 5'd13, 1'b0, 1'b0});
        s_op = 2'b10; #1;
        chk("dec_sra_ctl", {25'd0, sh_amt, sh_left, sh_signed}, {25'd0, 5'd13, 1'b0, 1'b1});
        s_op = 2'b11; #1;
        chk("dec_rsv_ctl", {25'd0, sh_amt, sh_left, sh_signed}, {25'd0, 5'd0, 1'b0, 1'b0});
        chk("dec_rsv_data", sh_data, 32'hA5A5_0F0F);
        tick();

        // SLL latency: m_valid two edges after accept
        m_ready = 1'b1;
        drive(2'b00, 5'd31, 32'h0000_0001, 4'd3);
        tick();
        s_valid = 1'b0;
        chk("lat_edge1_m_valid", 32'(m_valid), 32'd0);
        tick();
        chk("lat_edge2_m_valid", 32'(m_valid), 32'd1);
        chk("lat_m_data", m_data, 32'h8000_0000);
        chk("lat_m_tag", 32'(m_tag), 32'd3);
        tick();
        drain("drain_lat");

        one_op(2'b01, 5'd4, 32'hF000_0000, 4'd1);
        one_op(2'b10, 5'd4, 32'h8000_0000, 4'd2);
        one_op(2'b10, 5'd31, 32'h7FFF_FFFF, 4'd4);
        drain("drain_directed");

        // Back-to-back stream at full rate
        for (int i = 0; i < 16; i++) begin
            drive(2'(i % 3), 5'($urandom_range(0, 31)), $urandom, 4'(i));
            chk("stream_s_ready", 32'(s_ready), 32'd1);
            tick();
        end
        s_valid = 1'b0;
        drain("drain_stream");

        // Backpressure: exactly DEPTH accepts, then s_ready low
        m_ready = 1'b0;
        acc_cnt = 0;
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 5'(i), 32'h0000_0101 + 32'(i), 4'(8 + i));
            tick();
        end
        chk("bp_accepts", 32'(acc_cnt), DEPTH);
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        chk("bp_head_data", m_data, exp_q[0].data);
        tick();
        tick();
        chk("bp_hold_data", m_data, exp_q[0].data);
        chk("bp_hold_tag", 32'(m_tag), 32'(exp_q[0].tag));
        s_valid = 1'b0;
        m_ready = 1'b1;
        drain("drain_bp");
        chk("bp_pops", 32'(pop_cnt), DEPTH);

        // Reserved op: pass-through and sticky error
        one_op(2'b11, 5'd9, 32'h1234_5678, 4'd5);
        drain("drain_rsv");
        chk("rsv_err", 32'(err), 32'd1);
        tick();
        tick();
        chk("rsv_err_sticky", 32'(err), 32'd1);

        // Reset with one in flight and two queued
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 5'd1, 32'hDEAD_0000 + 32'(i), 4'(12 + i));
            tick();
        end
        s_valid = 1'b0;
        chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_m_data", m_data, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m_ready = 1'b1;
        pop_cnt = 0;
        one_op(2'b00, 5'd8, 32'h0000_00AB, 4'd7);
        drain("drain_post_rst");
        tick();
        tick();
        chk("post_rst_pops", 32'(pop_cnt), 32'd1);
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
